// File: rtl/primogen_arb_pkg.sv
// Shared types and helpers for the primogen arbiter.
package primogen_arb_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    GO   = 3'd1,
    BUSY = 3'd2,
    DONE = 3'd3,
    RESP = 3'd4
  } state_t;

  localparam int DEF_WIDTH = 16;

  // Ceiling log2 with a floor of 1 bit so that 1-wide counters stay legal
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/primogen_arb_if.sv
// Client-side request/response bus of the primogen arbiter.
interface primogen_arb_if
  import primogen_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = DEF_WIDTH
);
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  ack;
  logic [WIDTH-1:0] res;
  logic             err;

  modport master (output req, input ack, input res, input err);
  modport slave  (input req, output ack, output res, output err);
endinterface

// File: rtl/primogen_arb_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr.
module rr_arbiter
  import primogen_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  // Scan NREQ positions starting at ptr, wrapping, and keep the first hit
  always_comb begin
    logic found;
    int   j;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(ptr) + i) % NREQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/primogen_arb.sv
// Round-robin arbiter sharing one primogen generator among NREQ clients,
// with a watchdog that aborts a transaction if the generator hangs.
module primogen_arb
  import primogen_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst,
  primogen_arb_if.slave    bus,
  output logic             busy,
  output logic [31:0]      served,
  output logic             gen_go,
  input  logic             gen_ready,
  input  logic             gen_error,
  input  logic [WIDTH-1:0] gen_res
);

  localparam int IW  = clog2(NREQ);
  localparam int WDW = clog2(TIMEOUT + 1);

  state_t          state;
  state_t          state_n;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   grant;
  logic [NREQ-1:0] grant_oh;
  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;
  logic [WDW-1:0]  wd;
  logic            bcnt;
  logic            ready_q;
  logic            rise;
  logic            wd_hit;
  logic            latch_gen;
  logic            abort;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req (bus.req),
    .ptr (ptr),
    .gnt (pick_oh),
    .idx (pick_idx)
  );

  // Event decode: ready edge, watchdog expiry, and which result source wins
  always_comb begin
    rise      = gen_ready && !ready_q;
    wd_hit    = ((state == BUSY) || (state == DONE)) && (wd == WDW'(TIMEOUT - 1));
    latch_gen = (state == DONE) && rise;
    abort     = wd_hit && !latch_gen;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic; a ready edge in DONE beats a simultaneous watchdog expiry
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (|bus.req) state_n = GO;
      GO:   state_n = BUSY;
      BUSY: begin
        if (wd_hit)                       state_n = RESP;
        else if (!gen_ready || bcnt)      state_n = DONE;
      end
      DONE: if (rise || wd_hit) state_n = RESP;
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    gen_go  = (state == GO);
    busy    = (state != IDLE);
    bus.ack = (state == RESP) ? grant_oh : '0;
  end

  // Grant capture in IDLE, held until RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant    <= '0;
      grant_oh <= '0;
    end else if (state == IDLE && |bus.req) begin
      grant    <= pick_idx;
      grant_oh <= pick_oh;
    end
  end

  // Watchdog, BUSY dwell counter and registered copy of gen_ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd      <= '0;
      bcnt    <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= gen_ready;
      if (state == GO) begin
        wd   <= '0;
        bcnt <= 1'b0;
      end else if (state == BUSY || state == DONE) begin
        wd <= wd + 1'b1;
        if (state == BUSY) bcnt <= 1'b1;
      end
    end
  end

  // Result registers: generator result on the ready edge, forced error on abort
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.res <= '0;
      bus.err <= 1'b0;
    end else if (latch_gen) begin
      bus.res <= gen_res;
      bus.err <= gen_error;
    end else if (abort) begin
      bus.res <= '0;
      bus.err <= 1'b1;
    end
  end

  // Served counter and round-robin pointer advance on each response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      served <= '0;
      ptr    <= '0;
    end else if (state == RESP) begin
      served <= served + 32'd1;
      ptr    <= (grant == IW'(NREQ - 1)) ? '0 : grant + 1'b1;
    end
  end

endmodule

// File: tb/tb_primogen_arb.sv
// Directed bench for primogen_arb with a behavioural primogen stub.
module tb_primogen_arb;

  logic        clk;
  logic        rst;
  logic        busy;
  logic [31:0] served;
  logic        gen_go;
  logic        gen_ready;
  logic        gen_error;
  logic [15:0] gen_res;

  int total = 0;
  int bad   = 0;

  // Stub generator control: 0 normal, 1 hang, 2 error
  int mode   = 0;
  int cnt    = 0;
  int pidx   = 0;
  int go_cnt = 0;
  int go_run = 0;
  int go_max = 0;
  logic [15:0] primes [0:9] = '{16'd2, 16'd3, 16'd5, 16'd7, 16'd11,
                                16'd13, 16'd17, 16'd19, 16'd23, 16'd29};

  primogen_arb_if #(.NREQ(4), .WIDTH(16)) bus ();

  primogen_arb #(.NREQ(4), .WIDTH(16), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .served    (served),
    .gen_go    (gen_go),
    .gen_ready (gen_ready),
    .gen_error (gen_error),
    .gen_res   (gen_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generator stub: ready idles high, drops on go, rises 3 cycles later with the next prime
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      gen_ready <= 1'b1;
      gen_error <= 1'b0;
      gen_res   <= '0;
      cnt       <= 0;
      pidx      <= 0;
    end else if (gen_go) begin
      gen_ready <= 1'b0;
      cnt       <= 3;
    end else if (!gen_ready && mode != 1) begin
      if (cnt <= 1) begin
        gen_ready <= 1'b1;
        gen_res   <= primes[pidx];
        gen_error <= (mode == 2);
        pidx      <= pidx + 1;
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  // gen_go pulse monitor
  always @(posedge clk) begin
    if (gen_go) begin
      go_cnt++;
      go_run++;
      if (go_run > go_max) go_max = go_run;
    end else begin
      go_run = 0;
    end
  end

  task automatic do_reset();
    rst     = 1'b1;
    bus.req = '0;
    mode    = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_ack(output logic [3:0] a, output int cyc);
    logic done;
    a    = '0;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.ack != 0) begin
        a    = bus.ack;
        done = 1'b1;
      end
    end
  endtask

  task automatic wait_go(output int cyc);
    cyc = 0;
    while (!gen_go && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    total++;
    if (gen_go !== 1'b1) begin
      bad++;
      $display("FAIL wait_go: gen_go=%b required 1 within 50 cycles", gen_go);
    end
  endtask

  task automatic test_reset();
    logic [3:0] a;
    int cyc;
    int g0;
    rst     = 1'b1;
    bus.req = 4'b1111;
    g0      = go_cnt;
    @(posedge clk);
    @(posedge clk);
    #1;
    total++; if (bus.ack !== 4'b0) begin bad++; $display("FAIL rst_ack: got %b want 0000", bus.ack); end
    total++; if (bus.res !== 16'd0) begin bad++; $display("FAIL rst_res: got %0d want 0", bus.res); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", bus.err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (served !== 32'd0) begin bad++; $display("FAIL rst_served: got %0d want 0", served); end
    total++; if (gen_go !== 1'b0 || go_cnt != g0) begin bad++; $display("FAIL rst_go: gen_go=%b pulses=%0d want none", gen_go, go_cnt - g0); end
    rst = 1'b0;
    wait_ack(a, cyc);
    bus.req = '0;
    total++; if (a !== 4'b0001) begin bad++; $display("FAIL rst_first_grant: got %b want 0001", a); end
    total++; if (cyc != 6) begin bad++; $display("FAIL rst_latency: got %0d want 6", cyc); end
    total++; if (bus.res !== 16'd2) begin bad++; $display("FAIL rst_first_res: got %0d want 2", bus.res); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [3:0] a;
    int cyc;
    int g0;
    do_reset();
    g0 = go_cnt;
    for (int i = 0; i < 3; i++) begin
      bus.req = 4'b0100;
      wait_ack(a, cyc);
      bus.req = '0;
      total++; if (a !== 4'b0100) begin bad++; $display("FAIL single_ack%0d: got %b want 0100", i, a); end
      total++; if (bus.res !== primes[i]) begin bad++; $display("FAIL single_res%0d: got %0d want %0d", i, bus.res, primes[i]); end
      total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL single_err%0d: got %b want 0", i, bus.err); end
      @(posedge clk); #1;
    end
    total++; if (served !== 32'd3) begin bad++; $display("FAIL single_served: got %0d want 3", served); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle: busy=%b want 0", busy); end
    total++; if (go_cnt - g0 != 3) begin bad++; $display("FAIL single_go_count: got %0d want 3", go_cnt - g0); end
    total++; if (go_max != 1) begin bad++; $display("FAIL single_go_width: got %0d want 1", go_max); end
  endtask

  task automatic test_round_robin();
    logic [3:0] a;
    logic [3:0] exp_a;
    int cyc;
    do_reset();
    bus.req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      wait_ack(a, cyc);
      exp_a = 4'b0001 << (i % 4);
      total++; if (a !== exp_a) begin bad++; $display("FAIL rr_ack%0d: got %b want %b", i, a, exp_a); end
      total++; if (bus.res !== primes[i]) begin bad++; $display("FAIL rr_res%0d: got %0d want %0d", i, bus.res, primes[i]); end
    end
    bus.req = '0;
    @(posedge clk); #1;
    total++; if (served !== 32'd8) begin bad++; $display("FAIL rr_served: got %0d want 8", served); end
  endtask

  task automatic test_drop();
    logic [3:0] a;
    int cyc;
    do_reset();
    bus.req = 4'b0010;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.req = 4'b0000;
    wait_ack(a, cyc);
    total++; if (a !== 4'b0010) begin bad++; $display("FAIL drop_ack: got %b want 0010", a); end
    total++; if (bus.res !== 16'd2) begin bad++; $display("FAIL drop_res: got %0d want 2", bus.res); end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    logic [3:0] a;
    int cyc;
    do_reset();
    bus.req = 4'b0001;
    wait_ack(a, cyc);
    bus.req = '0;
    total++; if (bus.res !== 16'd2) begin bad++; $display("FAIL to_pre_res: got %0d want 2", bus.res); end
    @(posedge clk); #1;
    mode    = 1;
    bus.req = 4'b0001;
    wait_go(cyc);
    wait_ack(a, cyc);
    bus.req = '0;
    total++; if (cyc != 17) begin bad++; $display("FAIL to_latency: got %0d want 17", cyc); end
    total++; if (a !== 4'b0001) begin bad++; $display("FAIL to_ack: got %b want 0001", a); end
    total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL to_err: got %b want 1", bus.err); end
    total++; if (bus.res !== 16'd0) begin bad++; $display("FAIL to_res: got %0d want 0", bus.res); end
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL to_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_gen_error();
    logic [3:0] a;
    int cyc;
    do_reset();
    mode    = 2;
    bus.req = 4'b0010;
    wait_ack(a, cyc);
    bus.req = '0;
    total++; if (a !== 4'b0010) begin bad++; $display("FAIL gerr_ack: got %b want 0010", a); end
    total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL gerr_err: got %b want 1", bus.err); end
    total++; if (bus.res !== 16'd2) begin bad++; $display("FAIL gerr_res: got %0d want 2", bus.res); end
    @(posedge clk); #1;
    mode    = 0;
    bus.req = 4'b0010;
    wait_ack(a, cyc);
    bus.req = '0;
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL gerr_clear: got %b want 0", bus.err); end
    total++; if (bus.res !== 16'd3) begin bad++; $display("FAIL gerr_next_res: got %0d want 3", bus.res); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [3:0] a;
    int cyc;
    int acks;
    do_reset();
    bus.req = 4'b0001;
    wait_ack(a, cyc);
    bus.req = '0;
    total++; if (a !== 4'b0001) begin bad++; $display("FAIL mid_pre_ack: got %b want 0001", a); end
    @(posedge clk); #1;
    bus.req = 4'b0100;
    wait_go(cyc);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    rst     = 1'b0;
    bus.req = '0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.ack != 0) acks++;
    end
    total++; if (acks != 0) begin bad++; $display("FAIL mid_no_ack: got %0d acks want 0", acks); end
    bus.req = 4'b1111;
    wait_ack(a, cyc);
    bus.req = '0;
    total++; if (a !== 4'b0001) begin bad++; $display("FAIL mid_next_ack: got %b want 0001", a); end
    total++; if (bus.res !== 16'd2) begin bad++; $display("FAIL mid_next_res: got %0d want 2", bus.res); end
    @(posedge clk); #1;
  endtask

  initial begin
    rst     = 1'b1;
    bus.req = '0;
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_drop();
    test_timeout();
    test_gen_error();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
